// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : memory-stage load/store unit with variable-latency bus,
//                 store lane alignment, load extension and pipeline stall.
// Revision 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ResultSrcM_i,
    input  logic [2:0]  LoadTypeM_i,
    input  logic [2:0]  MemWriteM_i,
    input  logic [31:0] ALUResultM_i,
    input  logic [31:0] WriteDataM_i,
    output logic        Stall_M_o,
    output logic [31:0] ReadDataM_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int             CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             is_store, is_load, is_byte, is_half;
    logic             misal, access, go;
    logic             req, stall, capture, timeout_fire, timeout_hit;
    logic [15:0]      half_lane;
    logic [7:0]       byte_lane;
    logic [31:0]      load_ext;

    // Access decode; a store shadows a simultaneous load.
    always_comb begin
        is_store = (MemWriteM_i[2] == 1'b0) && (MemWriteM_i[1:0] != 2'b00);
        is_load  = (ResultSrcM_i == 2'b01) && !is_store;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        if (is_store) begin
            is_byte = (MemWriteM_i[1:0] == 2'b01);
            is_half = (MemWriteM_i[1:0] == 2'b10);
        end else begin
            is_byte = (LoadTypeM_i[1:0] == 2'b00);
            is_half = (LoadTypeM_i[1:0] == 2'b01);
        end
        misal  = is_half ? ALUResultM_i[0] : (!is_byte && (ALUResultM_i[1:0] != 2'b00));
        access = is_store || is_load;
        go     = access && !misal;
    end

    always_comb begin
        mem_be_o    = 4'hF;
        mem_wdata_o = WriteDataM_i;
        if (is_store) begin
            if (is_byte) begin
                mem_be_o    = 4'b0001 << ALUResultM_i[1:0];
                mem_wdata_o = {4{WriteDataM_i[7:0]}};
            end else if (is_half) begin
                mem_be_o    = 4'b0011 << ALUResultM_i[1:0];
                mem_wdata_o = {2{WriteDataM_i[15:0]}};
            end
        end
    end

    always_comb begin
        half_lane = ALUResultM_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        byte_lane = ALUResultM_i[0] ? half_lane[15:8] : half_lane[7:0];
        load_ext  = mem_rdata_i;
        if (is_byte)
            load_ext = {{24{byte_lane[7] & ~LoadTypeM_i[2]}}, byte_lane};
        else if (is_half)
            load_ext = {{16{half_lane[15] & ~LoadTypeM_i[2]}}, half_lane};
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        state_nx     = state;
        req          = 1'b0;
        stall        = 1'b0;
        capture      = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (mem_ready_i) begin
                        state_nx = S_DONE;
                        capture  = is_load;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem_ready_i) begin
                    state_nx = S_DONE;
                    capture  = is_load;
                end else if (timeout_hit) begin
                    state_nx     = S_DONE;
                    timeout_fire = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bus_err_o   <= 1'b0;
            ReadDataM_o <= 32'h0;
        end else begin
            state     <= state_nx;
            bus_err_o <= timeout_fire;
            if (capture)
                ReadDataM_o <= load_ext;
            else if (timeout_fire)
                ReadDataM_o <= 32'h0;
            // WAIT is only entered from IDLE, so clearing in IDLE clears on entry.
            if (state == S_IDLE)
                cnt <= '0;
            else if ((state == S_WAIT) && (cnt != CNT_MAX))
                cnt <= cnt + 1'b1;
        end
    end

    // Reset drops the request in the same cycle, not at the next edge.
    assign mem_req_o  = rst_n & req;
    assign Stall_M_o  = rst_n & stall;
    assign misalign_o = access & misal;
    assign mem_we_o   = is_store;
    assign mem_addr_o = {ALUResultM_i[31:2], 2'b00};

endmodule
`default_nettype wire
